// File: rtl/fpu_merge_pkg.sv
// fpu_merge_pkg
//   Shared definitions for the split-lane FPU merge stage.
//   - FOP_CMPDH : op[7:0] encoding of the high-lane compare op
//   - lane_sel  : picks which lane's flags drive FUS for a given op
//   - lane_base : bit offset of a (port, lane) slice in a packed lane bus
//
// The compare opcode normally comes from fpoperations.sv. The fallback
// value below is only used when that file is not part of the build.
`ifndef fop_cmpDH
`define fop_cmpDH 8'h2C
`endif

package fpu_merge_pkg;

  localparam logic [7:0] FOP_CMPDH = `fop_cmpDH;

  // The high-lane compare reports through the top lane.
  // Every other op reports through lane 0.
  function automatic int lane_sel(input logic [7:0] op8, input int nlane);
    return (op8 == FOP_CMPDH) ? (nlane - 1) : 0;
  endfunction

  // Buses are packed port-major: port p, lane l at [(p*nlane+l)*w +: w].
  function automatic int lane_base(input int p, input int l, input int nlane, input int w);
    return (p * nlane + l) * w;
  endfunction

endpackage

// File: rtl/fpu_op_delay.sv
// fpu_op_delay
//   LAT-deep {vld, op} shift register for one issue port.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     en_i      : issue valid
//     op_i      : issued op
//     flush_i   : kills every in-flight op, including one issued this cycle
//     vld_o     : tail-stage valid
//     op_o      : tail-stage op
module fpu_op_delay #(
  parameter int LAT = 4,
  parameter int OPW = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic [OPW-1:0] op_i,
  input  logic           flush_i,
  output logic           vld_o,
  output logic [OPW-1:0] op_o
);

  logic [LAT-1:0] vld_q;
  logic [OPW-1:0] op_q [LAT];

  // A flush clears only the valid bits. The op fields keep shifting
  // because nothing downstream looks at them without a valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < LAT; k++) op_q[k] <= '0;
    end else begin
      vld_q[0] <= en_i & ~flush_i;
      op_q[0]  <= op_i;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1] & ~flush_i;
        op_q[k]  <= op_q[k-1];
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign op_o  = op_q[LAT-1];

endmodule

// File: rtl/fpu_lane_merge.sv
// fpu_lane_merge
//   Merges NLANE half-width lane results into one result per issue port.
//   Ports:
//     clk, rst       : clock, asynchronous active-high reset
//     u_en, u_op     : per-port issue valid / op
//     flush          : kill all in-flight ops
//     lane_fus       : per-lane compare flags
//     lane_ret       : per-lane retire words
//     lane_ret_en    : per-lane retire enables
//     sticky_clr     : clear sticky and lane_conflict
//     FUS, FUS_vld   : merged flags and valid per port, at issue + LAT
//     ret, ret_en    : OR of lane retire words / enables per port
//     sticky         : OR of every valid FUS since the last clear
//     lane_conflict  : per port, set when more than one lane retired in one cycle
//   There is no handshake. Issue is accepted every cycle with no backpressure,
//   and FUS_vld is a single-cycle strobe that the consumer must take.
module fpu_lane_merge #(
  parameter int NPORT = 3,
  parameter int NLANE = 2,
  parameter int LAT   = 4,
  parameter int OPW   = 13,
  parameter int FLW   = 6,
  parameter int RETW  = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORT-1:0]            u_en,
  input  logic [NPORT*OPW-1:0]        u_op,
  input  logic                        flush,
  input  logic [NPORT*NLANE*FLW-1:0]  lane_fus,
  input  logic [NPORT*NLANE*RETW-1:0] lane_ret,
  input  logic [NPORT*NLANE-1:0]      lane_ret_en,
  input  logic                        sticky_clr,
  output logic [NPORT*FLW-1:0]        FUS,
  output logic [NPORT-1:0]            FUS_vld,
  output logic [NPORT*RETW-1:0]       ret,
  output logic [NPORT-1:0]            ret_en,
  output logic [FLW-1:0]              sticky,
  output logic [NPORT-1:0]            lane_conflict
);

  import fpu_merge_pkg::*;

  logic [NPORT-1:0]     tail_vld;
  logic [NPORT*OPW-1:0] tail_op;
  logic [FLW-1:0]       fus_or;
  logic [NPORT-1:0]     multi_ret;
  logic [FLW-1:0]       sticky_q, sticky_d;
  logic [NPORT-1:0]     conflict_q, conflict_d;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fpu_op_delay #(
      .LAT (LAT),
      .OPW (OPW)
    ) u_delay (
      .clk     (clk),
      .rst     (rst),
      .en_i    (u_en[p]),
      .op_i    (u_op[p*OPW +: OPW]),
      .flush_i (flush),
      .vld_o   (tail_vld[p]),
      .op_o    (tail_op[p*OPW +: OPW])
    );
  end

  // Only op[7:0] steers lane selection. The upper op bits travel down the
  // pipe for completeness but are not consumed here.
  logic unused_tail_op;
  assign unused_tail_op = ^tail_op;

  always_comb begin : merge
    int sel;
    int cnt;
    sel       = 0;
    cnt       = 0;
    FUS       = '0;
    FUS_vld   = tail_vld;
    ret       = '0;
    ret_en    = '0;
    fus_or    = '0;
    multi_ret = '0;
    for (int pi = 0; pi < NPORT; pi++) begin
      sel = lane_sel(tail_op[pi*OPW +: 8], NLANE);
      if (tail_vld[pi]) begin
        FUS[pi*FLW +: FLW] = lane_fus[lane_base(pi, sel, NLANE, FLW) +: FLW];
      end
      // FUS is already zero for an invalid port, so a plain OR is enough.
      fus_or = fus_or | FUS[pi*FLW +: FLW];
      // Idle lanes drive zero, so the retire merge needs no gating.
      cnt = 0;
      for (int l = 0; l < NLANE; l++) begin
        ret[pi*RETW +: RETW] = ret[pi*RETW +: RETW]
                               | lane_ret[lane_base(pi, l, NLANE, RETW) +: RETW];
        ret_en[pi] = ret_en[pi] | lane_ret_en[pi*NLANE + l];
        cnt = cnt + int'(lane_ret_en[pi*NLANE + l]);
      end
      multi_ret[pi] = (cnt > 1);
    end
  end

  // A result that lands in the same cycle as a clear is kept.
  // A conflict that occurs in the same cycle as a clear is also kept.
  assign sticky_d   = (sticky_clr ? '0 : sticky_q) | fus_or;
  assign conflict_d = (sticky_clr ? '0 : conflict_q) | multi_ret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q   <= '0;
      conflict_q <= '0;
    end else begin
      sticky_q   <= sticky_d;
      conflict_q <= conflict_d;
    end
  end

  assign sticky        = sticky_q;
  assign lane_conflict = conflict_q;

endmodule

// File: tb/tb_fpu_lane_merge.sv
// tb_fpu_lane_merge
//   Directed bench for fpu_lane_merge. Two instances are used:
//     dut  : default build (3 ports, 2 lanes, latency 4)
//     dut2 : 1 port, 4 lanes, latency 2
//   Issue tasks push {expected cycle, expected FUS} into per-port queues.
//   Negedge monitors pop those entries whenever FUS_vld is seen.
module tb_fpu_lane_merge;
  import fpu_merge_pkg::*;

  localparam int NPORT = 3, NLANE = 2, LAT = 4, OPW = 13, FLW = 6, RETW = 14;
  localparam int NL2 = 4, LAT2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- dut (default build) ----------------
  logic [NPORT-1:0]            u_en;
  logic [NPORT*OPW-1:0]        u_op;
  logic                        flush;
  logic [NPORT*NLANE*FLW-1:0]  lane_fus;
  logic [NPORT*NLANE*RETW-1:0] lane_ret;
  logic [NPORT*NLANE-1:0]      lane_ret_en;
  logic                        sticky_clr;
  logic [NPORT*FLW-1:0]        FUS;
  logic [NPORT-1:0]            FUS_vld;
  logic [NPORT*RETW-1:0]       ret;
  logic [NPORT-1:0]            ret_en;
  logic [FLW-1:0]              sticky;
  logic [NPORT-1:0]            lane_conflict;

  fpu_lane_merge #(
    .NPORT(NPORT), .NLANE(NLANE), .LAT(LAT), .OPW(OPW), .FLW(FLW), .RETW(RETW)
  ) dut (
    .clk(clk), .rst(rst), .u_en(u_en), .u_op(u_op), .flush(flush),
    .lane_fus(lane_fus), .lane_ret(lane_ret), .lane_ret_en(lane_ret_en),
    .sticky_clr(sticky_clr), .FUS(FUS), .FUS_vld(FUS_vld), .ret(ret),
    .ret_en(ret_en), .sticky(sticky), .lane_conflict(lane_conflict)
  );

  // ---------------- dut2 (1 port, 4 lanes, latency 2) ----------------
  logic [0:0]          u_en2;
  logic [OPW-1:0]      u_op2;
  logic [NL2*FLW-1:0]  lane_fus2;
  logic [NL2*RETW-1:0] lane_ret2;
  logic [NL2-1:0]      lane_ret_en2;
  logic [FLW-1:0]      FUS2;
  logic [0:0]          FUS_vld2;
  logic [RETW-1:0]     ret2;
  logic [0:0]          ret_en2;
  logic [FLW-1:0]      sticky2;
  logic [0:0]          conflict2;

  fpu_lane_merge #(
    .NPORT(1), .NLANE(NL2), .LAT(LAT2), .OPW(OPW), .FLW(FLW), .RETW(RETW)
  ) dut2 (
    .clk(clk), .rst(rst), .u_en(u_en2), .u_op(u_op2), .flush(1'b0),
    .lane_fus(lane_fus2), .lane_ret(lane_ret2), .lane_ret_en(lane_ret_en2),
    .sticky_clr(1'b0), .FUS(FUS2), .FUS_vld(FUS_vld2), .ret(ret2),
    .ret_en(ret_en2), .sticky(sticky2), .lane_conflict(conflict2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q [NPORT][$];   // {expected cycle[31:0], expected FUS[5:0]}
  logic [37:0] exp2_q[$];

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NPORT; p++) begin
        if (FUS_vld[p]) begin
          if (exp_q[p].size() == 0) begin
            cmp($sformatf("spurious_vld_p%0d", p), 64'(FUS_vld[p]), 64'd0);
          end else begin
            logic [37:0] e;
            e = exp_q[p].pop_front();
            cmp($sformatf("vld_cycle_p%0d", p), 64'(cyc), 64'(e[37:6]));
            cmp($sformatf("fus_p%0d", p), 64'(FUS[p*FLW +: FLW]), 64'(e[5:0]));
          end
        end else begin
          cmp($sformatf("fus_idle_zero_p%0d", p), 64'(FUS[p*FLW +: FLW]), 64'd0);
        end
      end
      if (FUS_vld2[0]) begin
        if (exp2_q.size() == 0) begin
          cmp("spurious_vld_dut2", 64'(FUS_vld2), 64'd0);
        end else begin
          logic [37:0] e2;
          e2 = exp2_q.pop_front();
          cmp("vld_cycle_dut2", 64'(cyc), 64'(e2[37:6]));
          cmp("fus_dut2", 64'(FUS2), 64'(e2[5:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_fus(input int p, input int l, input logic [FLW-1:0] v);
    lane_fus[(p*NLANE + l)*FLW +: FLW] = v;
  endtask

  task automatic issue(input int p, input logic [7:0] op8, input logic [FLW-1:0] fus_exp,
                       input bit expect_it);
    u_en[p] = 1'b1;
    u_op[p*OPW +: OPW] = {5'($urandom_range(0, 31)), op8};
    if (expect_it) exp_q[p].push_back({32'(cyc + LAT), fus_exp});
  endtask

  task automatic issue2(input logic [7:0] op8, input logic [FLW-1:0] fus_exp);
    u_en2 = 1'b1;
    u_op2 = {5'($urandom_range(0, 31)), op8};
    exp2_q.push_back({32'(cyc + LAT2), fus_exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with garbage on every input.
    rst          = 1'b1;
    u_en         = '1;
    u_op         = 39'({$urandom(), $urandom()});
    flush        = 1'b1;
    lane_fus     = 36'({$urandom(), $urandom()});
    lane_ret     = 84'({$urandom(), $urandom(), $urandom()});
    lane_ret_en  = '1;
    sticky_clr   = 1'b0;
    u_en2        = 1'b1;
    u_op2        = 13'($urandom());
    lane_fus2    = 24'($urandom());
    lane_ret2    = 56'({$urandom(), $urandom()});
    lane_ret_en2 = '1;
    step(3);
    cmp("rst_fus", 64'(FUS), 64'd0);
    cmp("rst_fus_vld", 64'(FUS_vld), 64'd0);
    cmp("rst_sticky", 64'(sticky), 64'd0);
    cmp("rst_conflict", 64'(lane_conflict), 64'd0);
    cmp("rst_fus_dut2", 64'(FUS2), 64'd0);

    u_en = '0; u_op = '0; flush = 1'b0; lane_fus = '0; lane_ret = '0; lane_ret_en = '0;
    u_en2 = '0; u_op2 = '0; lane_fus2 = '0; lane_ret2 = '0; lane_ret_en2 = '0;
    step(1);
    rst = 1'b0;
    step(2);

    // Port 0 cmpDH: high lane (0x2A) is selected over low lane (0x15).
    set_fus(0, 1, 6'h2A);
    set_fus(0, 0, 6'h15);
    issue(0, FOP_CMPDH, 6'h2A, 1'b1);
    step(1);
    u_en = '0;
    step(3);
    cmp("sticky_before_t5", 64'(sticky), 64'd0);
    step(1);
    cmp("sticky_2a_at_t5", 64'(sticky), 64'h2A);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    cmp("sticky_cleared", 64'(sticky), 64'd0);

    // All three ports in one cycle, with a mix of lane choices.
    set_fus(1, 0, 6'h11); set_fus(1, 1, 6'h0C);
    set_fus(2, 0, 6'h01); set_fus(2, 1, 6'h3F);
    issue(0, 8'h00, 6'h15, 1'b1);
    issue(1, FOP_CMPDH, 6'h0C, 1'b1);
    issue(2, 8'h01, 6'h01, 1'b1);
    step(1);
    u_en = '0;
    step(4);
    cmp("sticky_three_ports", 64'(sticky), 64'h1D);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;

    // Issue back-to-back on port 0 and flush on the third cycle.
    // Only the op issued after the flush cycle may retire.
    for (int i = 0; i < 4; i++) begin
      issue(0, FOP_CMPDH, 6'h2A, i == 3);
      flush = (i == 2);
      step(1);
    end
    u_en  = '0;
    flush = 1'b0;
    step(5);
    cmp("sticky_after_flush", 64'(sticky), 64'h2A);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;

    // Retire merge and lane conflict.
    lane_ret[(1*NLANE + 0)*RETW +: RETW] = 14'h1234;
    lane_ret[(1*NLANE + 1)*RETW +: RETW] = 14'h0A0F;
    lane_ret[(0*NLANE + 0)*RETW +: RETW] = 14'h0155;
    lane_ret_en = 6'b00_11_01;
    #1;
    cmp("ret_p1_or", 64'(ret[1*RETW +: RETW]), 64'h1A3F);
    cmp("ret_p0_single", 64'(ret[0 +: RETW]), 64'h0155);
    cmp("ret_en", 64'(ret_en), 64'b011);
    cmp("conflict_not_yet", 64'(lane_conflict), 64'd0);
    step(1);
    lane_ret    = '0;
    lane_ret_en = '0;
    cmp("conflict_p1_set", 64'(lane_conflict), 64'b010);
    step(3);
    cmp("conflict_p1_holds", 64'(lane_conflict), 64'b010);
    // Clearing in the same cycle as a new port-2 conflict keeps only port 2.
    sticky_clr  = 1'b1;
    lane_ret_en = 6'b11_00_00;
    step(1);
    sticky_clr  = 1'b0;
    lane_ret_en = '0;
    cmp("conflict_set_wins", 64'(lane_conflict), 64'b100);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    cmp("conflict_cleared", 64'(lane_conflict), 64'd0);

    // Clear coincident with a valid result: the result survives.
    set_fus(0, 1, 6'h30);
    issue(0, FOP_CMPDH, 6'h30, 1'b1);
    step(1);
    u_en = '0;
    step(4);
    cmp("sticky_30", 64'(sticky), 64'h30);
    set_fus(0, 1, 6'h04);
    issue(0, FOP_CMPDH, 6'h04, 1'b1);
    step(1);
    u_en = '0;
    step(3);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    cmp("sticky_clr_keeps_result", 64'(sticky), 64'h04);

    // dut2: 4 lanes, latency 2, back-to-back issue. cmpDH selects lane 3.
    lane_fus2 = {6'h33, 6'h22, 6'h11, 6'h05};
    issue2(FOP_CMPDH, 6'h33); step(1);
    issue2(8'h01, 6'h05);     step(1);
    issue2(FOP_CMPDH, 6'h33); step(1);
    issue2(8'h7F, 6'h05);     step(1);
    u_en2 = '0;
    step(4);
    cmp("sticky_dut2", 64'(sticky2), 64'h37);

    // Reset in mid-flight: the op must never retire.
    issue(0, FOP_CMPDH, 6'h00, 1'b0);
    step(1);
    u_en = '0;
    step(1);
    #2 rst = 1'b1;
    #1;
    cmp("async_rst_sticky", 64'(sticky), 64'd0);
    cmp("async_rst_vld", 64'(FUS_vld), 64'd0);
    step(1);
    rst = 1'b0;
    step(LAT + 3);

    for (int p = 0; p < NPORT; p++) begin
      cmp($sformatf("queue_drained_p%0d", p), 64'(exp_q[p].size()), 64'd0);
    end
    cmp("queue_drained_dut2", 64'(exp2_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
